// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready stream among N requesters.
// Packets lock the grant until their last beat; the output is a one-entry register stage.
module stream_rr_arbiter #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int ID_W  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] data_in,
    input  logic [N-1:0]       vld_in,
    input  logic [N-1:0]       last_in,
    output logic [N-1:0]       rdy_in,
    output logic [WIDTH-1:0]   data_out,
    output logic               last_out,
    output logic [ID_W-1:0]    id_out,
    output logic               vld_out,
    input  logic               rdy_out
);

    logic             vld_q;
    logic [WIDTH-1:0] data_q;
    logic             last_q;
    logic [ID_W-1:0]  id_q;
    logic [ID_W-1:0]  ptr_q;
    logic             locked_q;
    logic [ID_W-1:0]  lock_id_q;

    logic             load_en;
    logic             grant_ok;
    logic             accept;
    logic             found;
    logic [ID_W-1:0]  sel;
    logic [ID_W-1:0]  ptr_d;
    logic [WIDTH-1:0] data_d;
    logic             last_d;
    int               j;

    // Scan from ptr upward with explicit wrap so non-power-of-two N never overflows.
    always_comb begin
        sel   = ptr_q;
        found = 1'b0;
        j     = 0;
        if (locked_q) begin
            sel = lock_id_q;
        end else begin
            for (int k = 0; k < N; k++) begin
                j = int'(ptr_q) + k;
                if (j >= N) j = j - N;
                if (!found && vld_in[j]) begin
                    sel   = ID_W'(j);
                    found = 1'b1;
                end
            end
        end
    end

    assign load_en  = !vld_q || rdy_out;
    assign grant_ok = locked_q || (|vld_in);
    assign accept   = load_en && grant_ok && vld_in[sel];
    assign data_d   = data_in[int'(sel)*WIDTH +: WIDTH];
    assign last_d   = last_in[sel];
    assign ptr_d    = (sel == ID_W'(N-1)) ? '0 : sel + 1'b1;

    always_comb begin
        rdy_in = '0;
        if (load_en && grant_ok) rdy_in[sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            id_q      <= '0;
            ptr_q     <= '0;
            locked_q  <= 1'b0;
            lock_id_q <= '0;
        end else if (load_en) begin
            vld_q <= accept;
            if (accept) begin
                data_q <= data_d;
                last_q <= last_d;
                id_q   <= sel;
                // Only the end of a packet releases the lock and rotates priority.
                if (last_d) begin
                    locked_q <= 1'b0;
                    ptr_q    <= ptr_d;
                end else begin
                    locked_q  <= 1'b1;
                    lock_id_q <= sel;
                end
            end
        end
    end

    assign vld_out  = vld_q;
    assign data_out = data_q;
    assign last_out = last_q;
    assign id_out   = id_q;

endmodule
